outport_uart_tx: RTL and testbench

- Consumer at the far end of the CPU output port.
- Captures every word the CPU writes to the outport into a small FIFO.
- Serializes each captured word over a UART 8N1 line, least-significant byte first.
- Sits beside the outport register and runs off the same divided CPU clock, so software output can be logged on a host terminal.

---
 rtl/outport_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_outport_uart_tx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/outport_uart_tx.sv
// Buffers every CPU outport write in a small word FIFO and streams each word
// out as BYTES_PER_WORD UART 8N1 frames, least-significant byte first.
module outport_uart_tx #(
    parameter int REG_SIZE       = 32,
    parameter int BYTES_PER_WORD = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int CLKS_PER_BIT   = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        outport_wr,
    input  logic [REG_SIZE-1:0]         outport_data,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        fifo_full,
    output logic                        overflow,
    input  logic                        clear_overflow
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [REG_SIZE-1:0] fifo_mem [FIFO_DEPTH];

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [REG_SIZE-1:0] word_q, word_d;
    logic                overflow_q, overflow_d;
    logic                tx_q, tx_d;

    logic pop, push, drop, baud_wrap;

    // Fullness is judged after this cycle's pop, so a write racing a pop is kept.
    always_comb begin
        pop       = (state_q == IDLE) && (count_q != '0);
        push      = outport_wr && ((count_q != DEPTH_C) || pop);
        drop      = outport_wr && !push;
        baud_wrap = (baud_q == BAUD_LAST);
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        word_d     = word_q;
        overflow_d = overflow_q;
        tx_d       = 1'b1;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end

        if (state_q != IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (pop) begin
                    word_d   = fifo_mem[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    byte_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_wrap) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = word_q[bit_q];
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_wrap) begin
                    if (byte_q != BYTE_LAST) begin
                        byte_d  = byte_q + BYTE_W'(1);
                        word_d  = word_q >> 8;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= outport_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            word_q     <= '0;
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            word_q     <= word_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
        end
    end

    // Registered line driver keeps tx glitch-free; it trails the FSM by one cycle.
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign fifo_count = count_q;
    assign fifo_full  = (count_q == DEPTH_C);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_outport_uart_tx.sv
// Directed bench: stimulus queues expected bytes, a UART line monitor decodes
// frames on tx and scores them against that queue.
module tb_outport_uart_tx;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        outport_wr = 1'b0;
    logic        clear_overflow = 1'b0;
    logic [31:0] outport_data = '0;
    logic        tx, busy, fifo_full, overflow;
    logic [2:0]  fifo_count;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] expq [$];

    logic [31:0] w4 [6] = '{32'h11223344, 32'h55667788, 32'h99AABBCC,
                            32'hDDEEFF00, 32'h0BADF00D, 32'hDEADBEEF};
    logic [31:0] w5 [5] = '{32'h01020304, 32'hF0E0D0C0, 32'h7F800155,
                            32'h3C3CC3C3, 32'h00FF00FF};

    outport_uart_tx #(
        .REG_SIZE(32), .BYTES_PER_WORD(4), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .outport_wr(outport_wr),
        .outport_data(outport_data), .tx(tx), .busy(busy),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) expq.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_idle(input int maxc, input string name, output int at_cyc);
        int n = 0;
        while (busy !== 1'b0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        at_cyc = cyc;
        chk({name, "_idle_reached"}, {31'b0, busy}, 32'd0);
        repeat (4) @(negedge clk);
        chk({name, "_queue_drained"}, expq.size(), 32'd0);
    endtask

    // UART monitor: 10 bits of CPB samples each, every sample within a bit must agree.
    initial begin
        int         m_n = 0;
        bit         m_in = 1'b0;
        bit         m_ok = 1'b1;
        logic [9:0] m_bits = '0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_in = 1'b0;
            end else if (!m_in) begin
                if (tx === 1'b0) begin
                    m_in = 1'b1; m_n = 1; m_bits = '0; m_ok = 1'b1;
                end
            end else begin
                if (m_n % CPB == 0) m_bits[m_n/CPB] = tx;
                else if (tx !== m_bits[m_n/CPB]) m_ok = 1'b0;
                m_n++;
                if (m_n == 10*CPB) begin
                    m_in = 1'b0;
                    chk("frame_shape", {31'b0, m_ok && !m_bits[0] && m_bits[9]}, 32'd1);
                    if (expq.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_byte: got 0x%02h, required none", m_bits[8:1]);
                    end else begin
                        e = expq.pop_front();
                        $display("rx byte 0x%02h exp 0x%02h at cycle %0d", m_bits[8:1], e, cyc);
                        chk("rx_byte", {24'b0, m_bits[8:1]}, {24'b0, e});
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, t_end, n;

        // Reset state and quiet idle
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_count", {29'b0, fifo_count}, 32'd0);
        chk("rst_full", {31'b0, fifo_full}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_hold", {25'b0, tx, busy, fifo_count, fifo_full, overflow}, 32'b1000000);
        end

        // Single word, latency and total duration
        expq.push_back(8'h41); expq.push_back(8'h00);
        expq.push_back(8'h00); expq.push_back(8'h00);
        outport_wr = 1'b1; outport_data = 32'h00000041;
        @(negedge clk);
        outport_wr = 1'b0; c0 = cyc;
        chk("t2_count_after_write", {29'b0, fifo_count}, 32'd1);
        n = 0;
        while (tx !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        chk("t2_start_latency", cyc - c0, 32'd2);
        wait_idle(800, "t2", t_end);
        chk("t2_busy_drop_cycle", t_end - c0, 32'd641);

        // Byte order
        expq.push_back(8'h12); expq.push_back(8'h0F);
        expq.push_back(8'hC3); expq.push_back(8'hA5);
        outport_wr = 1'b1; outport_data = 32'hA5C30F12;
        @(negedge clk);
        outport_wr = 1'b0;
        wait_idle(800, "t3", t_end);

        // Six back-to-back writes: one popped, four buffered, one dropped
        for (int i = 0; i < 5; i++) push_word(w4[i]);
        for (int i = 0; i < 6; i++) begin
            outport_wr = 1'b1; outport_data = w4[i];
            @(negedge clk);
            if (i == 0) c0 = cyc;
            if (i == 1) chk("t4_count_push_pop", {29'b0, fifo_count}, 32'd1);
            if (i == 4) begin
                chk("t4_full_at_4", {31'b0, fifo_full}, 32'd1);
                chk("t4_no_overflow_yet", {31'b0, overflow}, 32'd0);
            end
        end
        outport_wr = 1'b0;
        chk("t4_count", {29'b0, fifo_count}, 32'd4);
        chk("t4_full", {31'b0, fifo_full}, 32'd1);
        chk("t4_overflow", {31'b0, overflow}, 32'd1);
        wait_idle(5*641 + 50, "t4", t_end);
        chk("t4_overflow_sticky", {31'b0, overflow}, 32'd1);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        chk("t4_overflow_cleared", {31'b0, overflow}, 32'd0);

        // Full FIFO: write coinciding with pop is kept; set beats clear
        for (int i = 0; i < 5; i++) push_word(w5[i]);
        for (int i = 0; i < 5; i++) begin
            outport_wr = 1'b1; outport_data = w5[i];
            @(negedge clk);
            if (i == 0) c0 = cyc;
        end
        outport_wr = 1'b0;
        chk("t5_full_before_pop", {31'b0, fifo_full}, 32'd1);
        while (cyc < c0 + 641) @(negedge clk);
        push_word(32'h5A5A0001);
        outport_wr = 1'b1; outport_data = 32'h5A5A0001;
        @(negedge clk);
        chk("t5_count_pop_write", {29'b0, fifo_count}, 32'd4);
        chk("t5_full_pop_write", {31'b0, fifo_full}, 32'd1);
        chk("t5_overflow_pop_write", {31'b0, overflow}, 32'd0);
        outport_data = 32'hFFFFFFFF; clear_overflow = 1'b1;
        @(negedge clk);
        outport_wr = 1'b0; clear_overflow = 1'b0;
        chk("t5_set_beats_clear", {31'b0, overflow}, 32'd1);
        chk("t5_count_after_drop", {29'b0, fifo_count}, 32'd4);
        wait_idle(6*641 + 50, "t5", t_end);

        // Reset in the middle of byte 1, bit 3 (byte 1 = 0xE7, bit 3 = 0)
        push_word(32'hC0FFE742); push_word(32'h13579BDF);
        outport_wr = 1'b1; outport_data = 32'hC0FFE742;
        @(negedge clk);
        c0 = cyc;
        outport_data = 32'h13579BDF;
        @(negedge clk);
        outport_wr = 1'b0;
        while (cyc < c0 + 232) @(negedge clk);
        chk("t6_mid_bit3_low", {31'b0, tx}, 32'd0);
        chk("t6_second_word_queued", {29'b0, fifo_count}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_tx", {31'b0, tx}, 32'd1);
        chk("t6_rst_busy", {31'b0, busy}, 32'd0);
        chk("t6_rst_count", {29'b0, fifo_count}, 32'd0);
        chk("t6_rst_overflow", {31'b0, overflow}, 32'd0);
        expq.delete();
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_idle_after_release", {30'b0, tx, busy}, 32'b10);
        push_word(32'h8C3A5E01);
        outport_wr = 1'b1; outport_data = 32'h8C3A5E01;
        @(negedge clk);
        outport_wr = 1'b0;
        wait_idle(800, "t6", t_end);

        chk("final_queue_empty", expq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
